// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared widths, op/state enums and byte-lane helper for ram_ctrl
package ram_ctrl_pkg;

    localparam int BYTE  = 8;
    localparam int NBITS = 8;
    localparam int WORDS = 2 ** NBITS;
    localparam int WORD  = 32;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_FETCH = 2'd2
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        FT,
        RSP
    } ctrl_state_t;

    // Byte idx of a word in memory order; big-endian puts idx 0 in the top lane.
    function automatic logic [BYTE-1:0] word_byte(input logic [WORD-1:0] w,
                                                  input logic [1:0] idx,
                                                  input logic big);
        logic [1:0] lane;
        lane = big ? ~idx : idx;
        case (lane)
            2'd0:    word_byte = w[BYTE-1:0];
            2'd1:    word_byte = w[2*BYTE-1:BYTE];
            2'd2:    word_byte = w[3*BYTE-1:2*BYTE];
            default: word_byte = w[4*BYTE-1:3*BYTE];
        endcase
    endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// rtl/ram_ctrl_if.sv - ram_bus: byte-wide synchronous RAM port shared by controller and RAM
interface ram_bus
    import ram_ctrl_pkg::*;
(
    input logic clk
);
    logic             we;
    logic [BYTE-1:0]  data;
    logic [NBITS-1:0] addr;
    logic [BYTE-1:0]  q;

    modport master (output we, output data, output addr, input q);
    modport slave  (input clk, input we, input data, input addr, output q);
endinterface

// File: rtl/ram.sv
// rtl/ram.sv - byte-wide synchronous RAM with one-cycle registered read data
module ram
    import ram_ctrl_pkg::*;
(
    ram_bus.slave bus
);
    logic [BYTE-1:0] mem_q [WORDS];
    logic [BYTE-1:0] q_q;

    // Read-during-write returns the old byte.
    always_ff @(posedge bus.clk) begin
        if (bus.we) begin
            mem_q[bus.addr] <= bus.data;
        end
        q_q <= mem_q[bus.addr];
    end

    assign bus.q = q_q;
endmodule

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - word/fetch to byte-beat RAM controller; FETCH_SEXT_EN sign-extends fetched bytes
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [NBITS-1:0] req_addr,
    input  logic [WORD-1:0]  req_wdata,
    output logic             rsp_valid,
    output logic [WORD-1:0]  rsp_rdata,
    ram_bus.master           bus
);
    ctrl_state_t      state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [2:0]       cap_q, cap_d;
    logic [NBITS-1:0] base_q, base_d;
    logic [WORD-1:0]  wdata_q, wdata_d;
    logic [WORD-1:0]  word_q, word_d;
    logic             we_q, we_d;
    logic [NBITS-1:0] addr_q, addr_d;
    logic [BYTE-1:0]  data_q, data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WORD-1:0]  rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            cap_q       <= 3'd0;
            base_q      <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cap_q       <= cap_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    logic [1:0]      nxt_beat;
    logic [WORD-1:0] shifted;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cap_d       = cap_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        nxt_beat    = beat_q + 2'd1;
        shifted     = BIG_ENDIAN ? {word_q[WORD-BYTE-1:0], bus.q}
                                 : {bus.q, word_q[WORD-1:BYTE]};

        case (state_q)
            IDLE: begin
                beat_d = 2'd0;
                cap_d  = 3'd0;
                if (req_valid && req_ready) begin
                    base_d  = req_addr;
                    wdata_d = req_wdata;
                    case (mem_op_t'(req_op))
                        OP_WRITE: begin
                            state_d = WR;
                            we_d    = 1'b1;
                            addr_d  = req_addr;
                            data_d  = word_byte(req_wdata, 2'd0, BIG_ENDIAN);
                        end
                        OP_READ: begin
                            state_d = RD;
                            addr_d  = req_addr;
                        end
                        OP_FETCH: begin
                            state_d = FT;
                            addr_d  = req_addr;
                        end
                        // Reserved op answers in the very next cycle, so it never leaves IDLE.
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = '0;
                        end
                    endcase
                end
            end
            WR: begin
                if (beat_q == 2'd3) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else begin
                    beat_d = nxt_beat;
                    we_d   = 1'b1;
                    addr_d = base_q + NBITS'(nxt_beat);
                    data_d = word_byte(wdata_q, nxt_beat, BIG_ENDIAN);
                end
            end
            RD: begin
                cap_d = cap_q + 3'd1;
                if (beat_q != 2'd3) begin
                    beat_d = nxt_beat;
                    addr_d = base_q + NBITS'(nxt_beat);
                end
                // q lags addr by one cycle, so captures run one edge behind the beats.
                if (cap_q != 3'd0) begin
                    word_d = shifted;
                end
                if (cap_q == 3'd4) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = shifted;
                    state_d     = IDLE;
                end
            end
            FT: begin
                cap_d = cap_q + 3'd1;
                if (cap_q == 3'd1) begin
                    rsp_valid_d = 1'b1;
`ifdef FETCH_SEXT_EN
                    rsp_rdata_d = {{(WORD-BYTE){bus.q[BYTE-1]}}, bus.q};
`else
                    rsp_rdata_d = {{(WORD-BYTE){1'b0}}, bus.q};
`endif
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) && !reset;
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
        bus.we    = we_q;
        bus.addr  = addr_q;
        bus.data  = data_q;
    end
endmodule
